// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan path.
package display_pkg;

  localparam int unsigned DIGIT_W_DEF = 4;
  localparam int unsigned MAX_DIGITS  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // One-hot decode of a digit index, truncated by the caller to its digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input int unsigned idx);
    digit_onehot = MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/display_scan_controller_slot_timer.sv
// Loadable down-counter that times SHOW and BLANK slots.
module slot_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o,
  output logic             tc_next_o
);

  logic [CNT_W-1:0] cnt_q;

  // Reload on request, otherwise count down and rest at zero.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // tc marks the last cycle of a slot; tc_next predicts it one cycle early
  // so the caller can register a pulse aligned with that cycle.
  assign tc_o      = (cnt_q == '0);
  assign tc_next_o = load_i ? (load_val_i == '0) : (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan sequencer with blanking and frame-aligned value updates.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 10000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_W      = DIGIT_W_DEF
) (
  input  logic                                      clk_i,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]             value_i,
  input  logic                                      value_valid_i,
  output logic                                      value_ready_o,
  output logic [((NUM_DIGITS>1)?$clog2(NUM_DIGITS):1)-1:0] digit_sel_o,
  output logic [NUM_DIGITS-1:0]                     digit_en_o,
  output logic [DIGIT_W-1:0]                        nibble_o,
  output logic                                      blank_o,
  output logic                                      frame_done_o
);

  localparam int unsigned VAL_W    = NUM_DIGITS * DIGIT_W;
  localparam int unsigned SEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SHOW_LEN = CLK_DIV - BLANK_CYCLES;
  localparam bit          HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_LEN - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_DIGITS - 1);
  localparam scan_state_t      LAST_STATE = HAS_BLANK ? BLANK : SHOW;

  scan_state_t             state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d, sel_inc;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    blank_q, blank_d;
  logic                    fd_q, fd_d;
  logic [VAL_W-1:0]        shadow_q, shadow_d;
  logic [VAL_W-1:0]        pending_q, pending_d;
  logic                    full_q, full_d;
  logic                    tmr_load, tmr_tc, tmr_tc_next;
  logic [CNT_W-1:0]        tmr_val;
  logic                    boundary, accept;

  slot_timer #(.CNT_W(CNT_W)) u_slot_timer (
    .clk_i      (clk_i),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc),
    .tc_next_o  (tmr_tc_next)
  );

  assign sel_inc = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);

  // Scan sequencing: next state, digit index, timer reload and frame boundary.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    boundary = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      sel_d    = '0;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = SHOW;
          sel_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
          boundary = 1'b1;
        end
        SHOW: begin
          if (tmr_tc) begin
            tmr_load = 1'b1;
            if (HAS_BLANK) begin
              state_d = BLANK;
              tmr_val = BLANK_LOAD;
            end else begin
              sel_d    = sel_inc;
              tmr_val  = SHOW_LOAD;
              boundary = (sel_q == LAST_SEL);
            end
          end
        end
        BLANK: begin
          if (tmr_tc) begin
            state_d  = SHOW;
            sel_d    = sel_inc;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LOAD;
            boundary = (sel_q == LAST_SEL);
          end
        end
        default: begin
          state_d  = IDLE;
          sel_d    = '0;
          tmr_load = 1'b1;
        end
      endcase
    end
  end

  // Registered display outputs derived from the next scan state.
  always_comb begin
    en_d    = (state_d == SHOW) ? NUM_DIGITS'(digit_onehot(32'(sel_d))) : '0;
    blank_d = (state_d != SHOW);
    fd_d    = tmr_tc_next && (state_d == LAST_STATE) && (sel_d == LAST_SEL);
  end

  // One-entry write buffer; commits to the shadow only on a frame boundary.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    full_d    = full_q;
    accept    = value_valid_i && !full_q;
    if (accept) begin
      pending_d = value_i;
      full_d    = 1'b1;
    end else if (boundary && full_q) begin
      shadow_d = pending_q;
      full_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      en_q      <= '0;
      blank_q   <= 1'b1;
      fd_q      <= 1'b0;
      shadow_q  <= '0;
      pending_q <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      blank_q   <= blank_d;
      fd_q      <= fd_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      full_q    <= full_d;
    end
  end

  assign value_ready_o = !full_q;
  assign digit_sel_o   = sel_q;
  assign digit_en_o    = en_q;
  assign blank_o       = blank_q;
  assign frame_done_o  = fd_q;
  assign nibble_o      = shadow_q[32'(sel_q) * DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (CLK_DIV=8, 4 digits; blanked and unblanked instances).
module tb_display_scan_controller;

  localparam int unsigned CLK_DIV = 8;

  typedef struct packed {
    logic [3:0] en;
    logic       blank;
    logic [1:0] sel;
    logic [3:0] nib;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] value = 16'h0;
  logic        valid = 1'b0;

  logic        a_ready, a_blank, a_fd;
  logic [1:0]  a_sel;
  logic [3:0]  a_en, a_nib;
  logic        b_ready, b_blank, b_fd;
  logic [1:0]  b_sel;
  logic [3:0]  b_en, b_nib;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  display_scan_controller #(.CLK_DIV(8), .BLANK_CYCLES(2), .NUM_DIGITS(4), .DIGIT_W(4)) dut_a (
    .clk_i(clk), .reset(reset), .enable(enable), .value_i(value), .value_valid_i(valid),
    .value_ready_o(a_ready), .digit_sel_o(a_sel), .digit_en_o(a_en), .nibble_o(a_nib),
    .blank_o(a_blank), .frame_done_o(a_fd));

  display_scan_controller #(.CLK_DIV(8), .BLANK_CYCLES(0), .NUM_DIGITS(4), .DIGIT_W(4)) dut_b (
    .clk_i(clk), .reset(reset), .enable(enable), .value_i(value), .value_valid_i(valid),
    .value_ready_o(b_ready), .digit_sel_o(b_sel), .digit_en_o(b_en), .nibble_o(b_nib),
    .blank_o(b_blank), .frame_done_o(b_fd));

  function automatic exp_t observe(input int which);
    if (which == 0) observe = {a_en, a_blank, a_sel, a_nib, a_fd};
    else            observe = {b_en, b_blank, b_sel, b_nib, b_fd};
  endfunction

  // Expected per-cycle outputs for n cycles of scanning value v from digit 0.
  task automatic push_frame(input logic [15:0] v, input int unsigned blank, input int unsigned n);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned slot = (k / CLK_DIV) % 4;
      int unsigned pos  = k % CLK_DIV;
      logic show = (pos < CLK_DIV - blank);
      e.en    = show ? 4'(1 << slot) : 4'b0;
      e.blank = !show;
      e.sel   = 2'(slot);
      e.nib   = v[slot*4 +: 4];
      e.fd    = ((k % 32) == 31);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input logic [3:0] nib, input int unsigned n);
    exp_t e;
    e = '{en: 4'b0, blank: 1'b1, sel: 2'd0, nib: nib, fd: 1'b0};
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic cycle_check(input int which, input string name);
    exp_t o, e;
    @(negedge clk);
    o = observe(which);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, observed=%h", name, o);
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL %s t=%0t: observed en=%b blank=%b sel=%0d nib=%h fd=%b required en=%b blank=%b sel=%0d nib=%h fd=%b",
                 name, $time, o.en, o.blank, o.sel, o.nib, o.fd, e.en, e.blank, e.sel, e.nib, e.fd);
      end
    end
  endtask

  task automatic test_reset();
    exp_t o, e;
    @(negedge clk);
    o = observe(0);
    e = '{en: 4'b0, blank: 1'b1, sel: 2'd0, nib: 4'h0, fd: 1'b0};
    checks++;
    if (o !== e) begin failures++; $display("FAIL reset_outputs: observed=%h required=%h", o, e); end
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: observed=%b required=1", a_ready); end
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    valid = 1'b1;
    value = 16'h1234;
    push_idle(4'h0, 1);
    cycle_check(0, "idle_write");
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL idle_ready_drop: observed=%b required=0", a_ready); end
    valid  = 1'b0;
    enable = 1'b1;
    push_frame(16'h1234, 2, 32);
    for (int k = 0; k < 32; k++) begin
      cycle_check(0, "first_frame");
      if (k == 0) begin
        checks++;
        if (a_ready !== 1'b1) begin failures++; $display("FAIL first_commit_ready: observed=%b required=1", a_ready); end
      end
    end
  endtask

  task automatic test_midframe_write();
    push_frame(16'h1234, 2, 32);
    for (int k = 0; k < 32; k++) begin
      cycle_check(0, "midframe_old");
      if (k == 9) begin
        valid = 1'b1;
        value = 16'hABCD;
      end
      if (k == 10) begin
        checks++;
        if (a_ready !== 1'b0) begin failures++; $display("FAIL midframe_ready_drop: observed=%b required=0", a_ready); end
        valid = 1'b0;
      end
    end
    push_frame(16'hABCD, 2, 32);
    for (int k = 0; k < 32; k++) begin
      cycle_check(0, "midframe_new");
      if (k == 0) begin
        checks++;
        if (a_ready !== 1'b1) begin failures++; $display("FAIL midframe_commit_ready: observed=%b required=1", a_ready); end
      end
    end
  endtask

  task automatic test_back_to_back();
    push_frame(16'hABCD, 2, 32);
    for (int k = 0; k < 32; k++) begin
      cycle_check(0, "b2b_stall_frame");
      if (k == 3) begin
        valid = 1'b1;
        value = 16'h1111;
      end else if (k >= 4) begin
        checks++;
        if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall k=%0d: observed ready=%b required=0", k, a_ready); end
        if (k == 4) value = 16'h2222;
      end
    end
    push_frame(16'h1111, 2, 32);
    for (int k = 0; k < 32; k++) begin
      cycle_check(0, "b2b_first");
      if (k == 0) begin
        checks++;
        if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_boundary_ready: observed=%b required=1", a_ready); end
      end
      if (k == 1) begin
        checks++;
        if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: observed=%b required=0", a_ready); end
        valid = 1'b0;
      end
    end
    push_frame(16'h2222, 2, 32);
    for (int k = 0; k < 32; k++) cycle_check(0, "b2b_second");
  endtask

  task automatic test_enable_drop();
    push_frame(16'h2222, 2, 18);
    for (int k = 0; k < 18; k++) cycle_check(0, "en_drop_pre");
    enable = 1'b0;
    push_idle(4'h2, 3);
    for (int k = 0; k < 3; k++) cycle_check(0, "en_drop_idle");
    enable = 1'b1;
    push_frame(16'h2222, 2, 32);
    for (int k = 0; k < 32; k++) cycle_check(0, "en_resume");
  endtask

  task automatic test_reset_midblank();
    exp_t o, e;
    push_frame(16'h2222, 2, 7);
    for (int k = 0; k < 7; k++) begin
      cycle_check(0, "rst_pre");
      if (k == 1) begin
        valid = 1'b1;
        value = 16'h5555;
      end
      if (k == 2) begin
        checks++;
        if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_pending_full: observed=%b required=0", a_ready); end
        valid = 1'b0;
      end
    end
    #1 reset = 1'b1;
    #1;
    o = observe(0);
    e = '{en: 4'b0, blank: 1'b1, sel: 2'd0, nib: 4'h0, fd: 1'b0};
    checks++;
    if (o !== e) begin failures++; $display("FAIL rst_async_outputs: observed=%h required=%h", o, e); end
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready: observed=%b required=1", a_ready); end
    @(negedge clk);
    reset = 1'b0;
    push_frame(16'h0000, 2, 32);
    for (int k = 0; k < 32; k++) cycle_check(0, "rst_after");
  endtask

  task automatic test_no_blank();
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b1;
    value = 16'h9876;
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b0) begin failures++; $display("FAIL noblank_accept: observed=%b required=0", b_ready); end
    valid  = 1'b0;
    enable = 1'b1;
    push_frame(16'h9876, 0, 64);
    for (int k = 0; k < 64; k++) cycle_check(1, "noblank_scan");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_midframe_write();
    test_back_to_back();
    test_enable_drop();
    test_reset_midblank();
    test_no_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
